// File: rtl/rr_arbiter_4_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   N_REQ            number of requesters sharing the mux datapath
//   arb_state_e      FSM state encoding (ST_IDLE = 0, ST_GRANT = 1)
//   hold_cnt_width() width of the consecutive-hold counter for a given MAX_HOLD
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // $clog2(MAX_HOLD), but never narrower than one bit (MAX_HOLD = 1 or 2).
    function automatic int hold_cnt_width(input int max_hold);
        if (max_hold <= 2) begin
            return 1;
        end else begin
            return $clog2(max_hold);
        end
    endfunction

endpackage : arb_pkg

// File: rtl/rr_arbiter_4_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4_if
// Request/grant bundle between the four requesters and the arbiter.
//   req   requester -> arbiter, bit i belongs to requester i (mux input a..d)
//   gnt   arbiter -> requesters, one-hot grant or zero
//   sel   arbiter -> mux, index of current or last owner
//   busy  arbiter -> requesters, high while any grant is held
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       sel;
    logic             busy;

    modport master (output req, input  gnt, input  sel, input  busy);
    modport slave  (input  req, output gnt, output sel, output busy);

endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4_pick.sv
// -----------------------------------------------------------------------------
// rr_pick_4
// Combinational round-robin pick: scans req starting at index `start` and
// wrapping mod 4; the first set bit wins.
//   req[3:0]   request vector
//   start[1:0] first index to examine
//   idx[1:0]   winning index (equals start when nothing is requested)
//   any        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       start,
    output logic [1:0]       idx,
    output logic             any
);

    logic [2*N_REQ-1:0] req_dbl_s;
    logic [N_REQ-1:0]   req_rot_s;
    logic [1:0]         offset_s;

    // Rotate req so that bit 0 is `start`, then take the lowest set bit.
    always_comb begin
        req_dbl_s = {req, req};
        req_rot_s = req_dbl_s[start +: N_REQ];
        offset_s  = 2'd0;
        casez (req_rot_s)
            4'b???1: offset_s = 2'd0;
            4'b??10: offset_s = 2'd1;
            4'b?100: offset_s = 2'd2;
            4'b1000: offset_s = 2'd3;
            default: offset_s = 2'd0;
        endcase
        idx = start + offset_s;
        any = |req;
    end

endmodule : rr_pick_4

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
// Round-robin arbiter owning the select of the shared mux_4_to_1 datapath.
// A grant is held while the owner keeps requesting, for at most MAX_HOLD
// consecutive cycles; on release the scan restarts just after the owner, so
// a timed-out owner ranks last and waiters are served fairly.
//   MAX_HOLD  maximum consecutive grant cycles (1..15)
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       rr_arbiter_4_if.slave: req in, gnt/sel/busy out (all registered)
// -----------------------------------------------------------------------------
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  bus
);

    localparam int            HW        = hold_cnt_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    arb_state_e       state_q,    state_d;
    logic [1:0]       ptr_q,      ptr_d;
    logic [1:0]       owner_q,    owner_d;
    logic [1:0]       sel_q,      sel_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic             busy_q,     busy_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;

    logic [1:0]       pick_start_s;
    logic [1:0]       pick_idx_s;
    logic             pick_any_s;
    logic             release_s;

    rr_pick_4 u_pick (
        .req   (bus.req),
        .start (pick_start_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Next-state logic for the FSM, pointer, hold counter and outputs.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        gnt_d        = gnt_q;
        busy_d       = busy_q;
        hold_cnt_d   = hold_cnt_q;
        release_s    = 1'b0;

        // While granted, the only pick that matters is the release pick,
        // which starts just after the owner (the new ptr value).
        if (state_q == ST_GRANT) begin
            pick_start_s = owner_q + 2'd1;
        end else begin
            pick_start_s = ptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx_s;
                    sel_d      = pick_idx_s;
                    gnt_d      = 4'b0001 << pick_idx_s;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                release_s = !bus.req[owner_q] || (hold_cnt_q == HOLD_LAST);
                if (release_s) begin
                    ptr_d      = owner_q + 2'd1;
                    hold_cnt_d = '0;
                    if (pick_any_s) begin
                        state_d = ST_GRANT;
                        owner_d = pick_idx_s;
                        sel_d   = pick_idx_s;
                        gnt_d   = 4'b0001 << pick_idx_s;
                        busy_d  = 1'b1;
                    end else begin
                        // sel keeps the last owner so the mux output stays stable.
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 4'b0000;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4
// Drives the same request vector into three arbiters (MAX_HOLD = 8, 2, 1)
// and compares every output each cycle with a cycle-level reference model,
// plus fixed expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_s;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter_4_if if8 ();
    rr_arbiter_4_if if2 ();
    rr_arbiter_4_if if1 ();

    assign if8.req = req_s;
    assign if2.req = req_s;
    assign if1.req = req_s;

    rr_arbiter_4 #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    rr_arbiter_4 #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    rr_arbiter_4 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    // Reference model: who owns the path, for how many cycles, where the
    // round-robin scan starts next, and what sel last showed.
    int max_hold [3] = '{8, 2, 1};
    bit m_active [3];
    int m_owner  [3];
    int m_held   [3];
    int m_ptr    [3];
    int m_sel    [3];

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rst_v);
        for (int u = 0; u < 3; u++) begin
            if (rst_v) begin
                m_active[u] = 1'b0;
                m_owner[u]  = 0;
                m_held[u]   = 0;
                m_ptr[u]    = 0;
                m_sel[u]    = 0;
            end else if (!m_active[u]) begin
                int w;
                w = first_from(r, m_ptr[u]);
                if (w >= 0) begin
                    m_active[u] = 1'b1;
                    m_owner[u]  = w;
                    m_sel[u]    = w;
                    m_held[u]   = 1;
                end
            end else if (!r[m_owner[u]] || m_held[u] == max_hold[u]) begin
                int w;
                m_ptr[u] = (m_owner[u] + 1) % 4;
                w = first_from(r, m_ptr[u]);
                if (w >= 0) begin
                    m_owner[u] = w;
                    m_sel[u]   = w;
                    m_held[u]  = 1;
                end else begin
                    m_active[u] = 1'b0;
                end
            end else begin
                m_held[u] = m_held[u] + 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int u);
        return m_active[u] ? (32'd1 << m_owner[u]) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gnt_h8",  32'(if8.gnt),  exp_gnt(0));
        chk("sel_h8",  32'(if8.sel),  32'(m_sel[0]));
        chk("busy_h8", 32'(if8.busy), 32'(m_active[0]));
        chk("gnt_h2",  32'(if2.gnt),  exp_gnt(1));
        chk("sel_h2",  32'(if2.sel),  32'(m_sel[1]));
        chk("busy_h2", 32'(if2.busy), 32'(m_active[1]));
        chk("gnt_h1",  32'(if1.gnt),  exp_gnt(2));
        chk("sel_h1",  32'(if1.sel),  32'(m_sel[2]));
        chk("busy_h1", 32'(if1.busy), 32'(m_active[2]));
    endtask

    // One clock: apply inputs, advance the model on the edge, sample #1 later.
    task automatic step(input logic [3:0] r, input logic rst_v);
        req_s = r;
        rst   = rst_v;
        @(posedge clk);
        model_step(r, rst_v);
        #1;
        check_all();
    endtask

    logic [3:0] rot_exp [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        logic [3:0] r;
        logic [3:0] flip;
        logic       rv;
        rst   = 1'b1;
        req_s = 4'b0000;

        // Reset state.
        step(4'b0000, 1'b1);
        chk("rst_gnt",  32'(if8.gnt),  32'h0);
        chk("rst_sel",  32'(if8.sel),  32'h0);
        chk("rst_busy", 32'(if8.busy), 32'h0);

        // Single request for three cycles, then drop.
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b0);
            chk("single_gnt", 32'(if8.gnt), 32'h2);
            chk("single_sel", 32'(if8.sel), 32'h1);
        end
        step(4'b0000, 1'b0);
        chk("single_rel_gnt",  32'(if8.gnt),  32'h0);
        chk("single_rel_busy", 32'(if8.busy), 32'h0);
        chk("single_rel_sel",  32'(if8.sel),  32'h1);

        // Reset mid-grant, then regrant on the next edge.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        chk("midrst_gnt",  32'(if8.gnt),  32'h0);
        chk("midrst_sel",  32'(if8.sel),  32'h0);
        chk("midrst_busy", 32'(if8.busy), 32'h0);
        step(4'b0100, 1'b0);
        chk("midrst_regrant", 32'(if8.gnt), 32'h4);

        // Rotation with all requesting, MAX_HOLD = 2.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(4'b1111, 1'b0);
            chk("rotate_h2", 32'(if2.gnt), 32'(rot_exp[i]));
        end

        // Sole requester past the hold limit keeps the grant.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, 1'b0);
            chk("sole_timeout", 32'(if8.gnt), 32'h8);
        end

        // Owner 3 releases: scan wraps to 0, then 1 after 0 releases.
        step(4'b0011, 1'b0);
        chk("wrap_gnt", 32'(if8.gnt), 32'h1);
        step(4'b0010, 1'b0);
        chk("handover_gnt", 32'(if8.gnt), 32'h2);

        // Late arrival does not disturb the current owner.
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0101, 1'b0);
        chk("late_hold0", 32'(if8.gnt), 32'h1);
        step(4'b0101, 1'b0);
        chk("late_hold1", 32'(if8.gnt), 32'h1);
        step(4'b0100, 1'b0);
        chk("late_switch", 32'(if8.gnt), 32'h4);

        // Random sticky requests with occasional resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                flip[b] = ($urandom_range(0, 3) == 0);
            end
            r  = r ^ flip;
            rv = ($urandom_range(0, 299) == 0);
            step(r, rv);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rr_arbiter_4
